baud_gen_prog: RTL and testbench

Programmable baud-rate generator for the external UART link. It replaces the fixed pass-through tick source with a clock divider whose rate is selectable at run time. It produces an oversampling tick for the receiver and a bit-rate tick for the transmitter. Rate changes are glitch-free: a new setting takes effect only on a bit boundary.

---
 rtl/baud_pkg.sv | 28 ++
 rtl/baud_gen_prog.sv | 99 +++++++++
 tb/tb_baud_gen_prog.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// baud_pkg: rate codes, standard rate table and divisor helper for the programmable baud generator.
package baud_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_14400  = 3'd1;
    localparam logic [2:0] BAUD_19200  = 3'd2;
    localparam logic [2:0] BAUD_38400  = 3'd3;
    localparam logic [2:0] BAUD_57600  = 3'd4;
    localparam logic [2:0] BAUD_115200 = 3'd5;
    localparam logic [2:0] BAUD_RSVD   = 3'd6;
    localparam logic [2:0] BAUD_CUSTOM = 3'd7;

    localparam int unsigned NUM_RATES = 6;
    localparam int unsigned BAUD_RATE [NUM_RATES] = '{9600, 14400, 19200, 38400, 57600, 115200};

    typedef enum logic {IDLE_CFG, PENDING} cfg_state_e;

    // Rounded clocks-per-os_tick; 64-bit math keeps rate*os and the rounding term exact.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned rate,
                                             input int unsigned os);
        longint unsigned num;
        longint unsigned den;
        den = 64'(rate) * 64'(os);
        num = 64'(clk_hz) + den / 2;
        return 32'(num / den);
    endfunction

endpackage

// File: rtl/baud_gen_prog.sv
// baud_gen_prog: run-time programmable baud divider producing oversample and bit-rate ticks,
// with rate changes deferred to a bit boundary.
module baud_gen_prog
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       rate_sel,
    input  logic [DIV_W-1:0] div_custom,
    input  logic             cfg_load,
    output logic             os_tick,
    output logic             tx_tick,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic [DIV_W-1:0] active_div
);

    localparam int unsigned PH_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam int unsigned TBL [8] = '{
        baud_div(CLK_HZ, BAUD_RATE[BAUD_9600], OVERSAMPLE),
        baud_div(CLK_HZ, BAUD_RATE[BAUD_14400], OVERSAMPLE),
        baud_div(CLK_HZ, BAUD_RATE[BAUD_19200], OVERSAMPLE),
        baud_div(CLK_HZ, BAUD_RATE[BAUD_38400], OVERSAMPLE),
        baud_div(CLK_HZ, BAUD_RATE[BAUD_57600], OVERSAMPLE),
        baud_div(CLK_HZ, BAUD_RATE[BAUD_115200], OVERSAMPLE),
        0,
        0
    };

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(TBL[0]);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);
    localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVERSAMPLE - 1);

    if (OVERSAMPLE < 2 || OVERSAMPLE > 64) begin : g_os_err
        $error("baud_gen_prog: OVERSAMPLE out of range 2..64");
    end

    for (genvar i = 0; i < NUM_RATES; i++) begin : g_tbl_chk
        if (TBL[i] < 2 || (TBL[i] >> DIV_W) != 0) begin : g_err
            $error("baud_gen_prog: table divisor below 2 or wider than DIV_W");
        end
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] active_div_q, active_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    cfg_state_e       state_q, state_d;
    logic             cfg_err_q, cfg_err_d;
    logic [DIV_W-1:0] load_div;
    logic             load_bad, load_ok, apply;

    always_comb begin
        load_div     = (rate_sel == BAUD_CUSTOM) ? div_custom : DIV_W'(TBL[rate_sel]);
        load_bad     = cfg_load && (rate_sel == BAUD_RSVD || (rate_sel == BAUD_CUSTOM && div_custom < DIV_TWO));
        load_ok      = cfg_load && !load_bad;
        os_tick      = en && (div_cnt_q == active_div_q - DIV_ONE);
        tx_tick      = os_tick && (phase_q == PH_LAST);
        // A halted divider has no bit boundary to wait for, so apply straight away.
        apply        = (state_q == PENDING) && (tx_tick || !en);
        div_cnt_d    = (apply || os_tick) ? '0 : en ? div_cnt_q + DIV_ONE : div_cnt_q;
        phase_d      = (apply || tx_tick) ? '0 : os_tick ? phase_q + PH_ONE : phase_q;
        active_div_d = apply ? pend_div_q : active_div_q;
        pend_div_d   = load_ok ? load_div : pend_div_q;
        state_d      = load_ok ? PENDING : apply ? IDLE_CFG : state_q;
        cfg_err_d    = load_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            phase_q      <= '0;
            active_div_q <= DIV_RST;
            pend_div_q   <= DIV_RST;
            state_q      <= IDLE_CFG;
            cfg_err_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            phase_q      <= phase_d;
            active_div_q <= active_div_d;
            pend_div_q   <= pend_div_d;
            state_q      <= state_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_pending = (state_q == PENDING);
    assign cfg_err     = cfg_err_q;
    assign active_div  = active_div_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// tb_baud_gen_prog: directed scoreboard bench for baud_gen_prog at default parameters.
module tb_baud_gen_prog;

    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [2:0]  rate_sel;
    logic [15:0] div_custom;
    logic        cfg_load;
    logic        os_tick;
    logic        tx_tick;
    logic        cfg_pending;
    logic        cfg_err;
    logic [15:0] active_div;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb[$];

    baud_gen_prog dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .rate_sel   (rate_sel),
        .div_custom (div_custom),
        .cfg_load   (cfg_load),
        .os_tick    (os_tick),
        .tx_tick    (tx_tick),
        .cfg_pending(cfg_pending),
        .cfg_err    (cfg_err),
        .active_div (active_div)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int val);
        sb.push_back('{tag, val});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0d with nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === 32'(e.val))
            else begin
                n_err++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Gap counts the current cycle as 1 and ends on the cycle showing the tick.
    task automatic next_os(output int g);
        g = 1;
        while (os_tick !== 1'b1 && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic next_tx(output int g);
        g = 1;
        while (tx_tick !== 1'b1 && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic load(input logic [2:0] sel, input logic [15:0] dc);
        rate_sel   = sel;
        div_custom = dc;
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
    endtask

    initial begin
        int g;
        int seen;
        reset = 1'b1; en = 1'b0; rate_sel = 3'd0; div_custom = '0; cfg_load = 1'b0;
        repeat (3) step();

        push("rst_os", 0);       check(32'(os_tick));
        push("rst_tx", 0);       check(32'(tx_tick));
        push("rst_pending", 0);  check(32'(cfg_pending));
        push("rst_err", 0);      check(32'(cfg_err));
        push("rst_active", 326); check(32'(active_div));

        // Default rate from reset release.
        push("first_tx", 5216);
        reset = 1'b0; en = 1'b1;
        next_tx(g); check(32'(g));
        push("tx_has_os", 1); check(32'(os_tick));
        push("tx_period_9600", 5216);
        step(); next_tx(g); check(32'(g));
        push("os_period_9600", 326);
        step(); next_os(g); check(32'(g));
        push("active_9600", 326); check(32'(active_div));

        // Mid-bit switch to 115200 waits for the bit boundary.
        push("pend_after_load", 1);
        push("active_before_apply", 326);
        push("tx_before_apply", 4890);
        push("pend_at_boundary", 1);
        load(3'd5, '0);
        check(32'(cfg_pending));
        check(32'(active_div));
        next_tx(g); check(32'(g));
        check(32'(cfg_pending));
        push("pend_cleared", 0);
        push("active_115200", 27);
        step();
        check(32'(cfg_pending));
        check(32'(active_div));
        push("tx_first_115200", 432); next_tx(g); check(32'(g));
        push("tx_period_115200", 432); step(); next_tx(g); check(32'(g));
        push("os_period_115200", 27); step(); next_os(g); check(32'(g));

        // Rejected loads.
        push("err_custom1", 1); push("err_custom1_pend", 0); push("err_custom1_active", 27);
        load(3'd7, 16'd1);
        check(32'(cfg_err)); check(32'(cfg_pending)); check(32'(active_div));
        push("err_custom1_pulse", 0); step(); check(32'(cfg_err));
        push("err_rsvd", 1); push("err_rsvd_pend", 0); push("err_rsvd_active", 27);
        load(3'd6, 16'd100);
        check(32'(cfg_err)); check(32'(cfg_pending)); check(32'(active_div));
        push("err_rsvd_pulse", 0); step(); check(32'(cfg_err));

        // Halted divider applies a load on the following cycle.
        en = 1'b0; step();
        push("halt_no_os", 0); check(32'(os_tick));
        push("halt_pend", 1); push("halt_active_old", 27);
        load(3'd3, '0);
        check(32'(cfg_pending)); check(32'(active_div));
        push("halt_active_new", 81); push("halt_pend_clr", 0);
        step();
        check(32'(active_div)); check(32'(cfg_pending));
        push("resume_first_os", 81);
        en = 1'b1;
        next_os(g); check(32'(g));

        // Freeze mid-count: counting resumes from the held value.
        step();
        repeat (10) step();
        en = 1'b0;
        seen = 0;
        repeat (20) begin
            step();
            if (os_tick !== 1'b0 || tx_tick !== 1'b0) seen++;
        end
        push("frozen_ticks", 0); check(32'(seen));
        push("resume_partial_os", 71);
        en = 1'b1;
        next_os(g); check(32'(g));

        // Load in the tx_tick cycle, then overwrite before the next boundary.
        next_tx(g);
        push("coinc_pend", 1); push("coinc_active_old", 81);
        load(3'd4, '0);
        check(32'(cfg_pending)); check(32'(active_div));
        push("overwrite_pend", 1);
        load(3'd2, '0);
        check(32'(cfg_pending));
        push("old_bit_persists", 1295); push("old_active_at_tx", 81);
        next_tx(g); check(32'(g)); check(32'(active_div));
        push("active_19200", 163); push("pend_19200_clr", 0);
        step();
        check(32'(active_div)); check(32'(cfg_pending));
        push("os_first_19200", 163);
        next_os(g); check(32'(g));

        // Reset discards a pending configuration.
        push("pre_rst_pend", 1);
        load(3'd1, '0);
        check(32'(cfg_pending));
        reset = 1'b1; step();
        push("rst2_pend", 0); push("rst2_active", 326); push("rst2_os", 0);
        push("rst2_tx", 0); push("rst2_err", 0);
        check(32'(cfg_pending)); check(32'(active_div)); check(32'(os_tick));
        check(32'(tx_tick)); check(32'(cfg_err));
        push("rst2_first_os", 326); push("rst2_no_apply", 326); push("rst2_pend_after", 0);
        reset = 1'b0;
        next_os(g); check(32'(g));
        check(32'(active_div)); check(32'(cfg_pending));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
